// File: rtl/pll_lock_supervisor_if.sv
// Lock-supervisor bus: PLL lock input plus the PLL reset, domain resets, ready and event counters.
// master = the supervisor, slave = the PLL/top-level side that consumes the resets.
interface pll_lock_supervisor_if #(
  parameter int NUM_DOMAINS = 6,
  parameter int CNT_W       = 8
);
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   ready;
  logic [CNT_W-1:0]       retry_count;
  logic [CNT_W-1:0]       lost_count;

  modport master (
    input  pll_locked,
    output pll_rst, dom_rst, ready, retry_count, lost_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, dom_rst, ready, retry_count, lost_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for lock, qualifies it, then releases domain resets in order.
// Latency: ready rises exactly 3 + STABLE_CYCLES + (NUM_DOMAINS-1)*RELEASE_GAP edges after the first edge sampling pll_locked high in WAIT_LOCK.
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS    = 6,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP    = 8,
  parameter int CNT_W          = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.master bus
);

  localparam int T_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX_B = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0]     TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0]     TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0]     RST_LAST   = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     TO_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]     ST_LAST    = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     GAP_LAST   = TIMER_W'(RELEASE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL    = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] DOM_NONE   = {NUM_DOMAINS{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       retry_q, retry_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
  logic [NUM_DOMAINS-1:0] dom_step;
  logic                   lk;

  assign lk       = sync2_q;
  // Shifting left clears the lowest still-set bit, so releases run strictly in ascending order.
  assign dom_step = dom_rst_q << 1;

  // Next-state, timer, output and counter computation.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TIMER_ONE;
    sync1_d   = bus.pll_locked;
    sync2_d   = sync1_q;
    pll_rst_d = 1'b0;
    dom_rst_d = dom_rst_q;
    ready_d   = 1'b0;
    retry_d   = retry_q;
    lost_d    = lost_q;
    case (state_q)
      S_PLL_RST: begin
        dom_rst_d = DOM_ALL;
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = TIMER_ZERO;
        end else begin
          pll_rst_d = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_d = S_STABLE;
          timer_d = TIMER_ZERO;
        end else if (timer_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          timer_d   = TIMER_ZERO;
          pll_rst_d = 1'b1;
          retry_d   = sat_inc(retry_q);
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          timer_d = TIMER_ZERO;
        end else if (timer_q == ST_LAST) begin
          dom_rst_d = dom_step;
          timer_d   = TIMER_ZERO;
          state_d   = (dom_step == DOM_NONE) ? S_RUN : S_RELEASE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_RELEASE: begin
        // Lock loss is tested first so it overrides a release step due on the same edge.
        if (!lk) begin
          state_d   = S_PLL_RST;
          timer_d   = TIMER_ZERO;
          pll_rst_d = 1'b1;
          dom_rst_d = DOM_ALL;
          lost_d    = sat_inc(lost_q);
        end else if (timer_q == GAP_LAST) begin
          dom_rst_d = dom_step;
          timer_d   = TIMER_ZERO;
          state_d   = (dom_step == DOM_NONE) ? S_RUN : S_RELEASE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_RUN: begin
        timer_d = TIMER_ZERO;
        if (!lk) begin
          state_d   = S_PLL_RST;
          pll_rst_d = 1'b1;
          dom_rst_d = DOM_ALL;
          lost_d    = sat_inc(lost_q);
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_PLL_RST;
        timer_d   = TIMER_ZERO;
        pll_rst_d = 1'b1;
        dom_rst_d = DOM_ALL;
      end
    endcase
  end

  // State, synchronizer and registered-output flops with synchronous reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      timer_q   <= TIMER_ZERO;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= DOM_ALL;
      ready_q   <= 1'b0;
      retry_q   <= CNT_ZERO;
      lost_q    <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pll_rst_q <= pll_rst_d;
      dom_rst_q <= dom_rst_d;
      ready_q   <= ready_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.dom_rst     = dom_rst_q;
  assign bus.ready       = ready_q;
  assign bus.retry_count = retry_q;
  assign bus.lost_count  = lost_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumes the PLL `locked` output in the `refclk` domain and drives the PLL `rst` input.
- Issues a PLL reset pulse, waits for lock with a timeout, and qualifies lock stability.
- Releases per-clock-domain resets in a fixed order (domain 0 first) and raises `ready`.
- On loss of lock it re-asserts all domain resets and restarts the sequence. Sits beside the ADC clock PLL at the top level.

Parameters:
- NUM_DOMAINS, 6, number of downstream domain resets (one per PLL output clock).
- PLL_RST_CYCLES, 16, width of the `pll_rst` pulse in `refclk` cycles (≥1).
- LOCK_TIMEOUT, 50000, cycles to wait for synchronized lock before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before releasing resets.
- RELEASE_GAP, 8, cycles between successive domain reset releases (≥1).
- CNT_W, 8, width of the saturating event counters.

Ports:
- refclk, input, 1, 50 MHz reference clock; sole clock.
- rst, input, 1, synchronous active-high reset.
- pll_locked, input, 1, PLL lock indicator; asynchronous to `refclk`.
- pll_rst, output, 1, reset request to the PLL; active-high.
- dom_rst, output, NUM_DOMAINS, per-domain resets, active-high; bit i is released i-th.
- ready, output, 1, high when all domains are out of reset and lock is held.
- retry_count, output, CNT_W, number of lock timeouts; saturates at all-ones.
- lost_count, output, CNT_W, number of lock losses after stable qualification; saturates.

Behaviour:
- Clock and reset: one clock, `refclk`; `rst` is synchronous and active-high.
- Reset values while `rst` is high:
  - `pll_rst` = 1.
  - `dom_rst` = all ones.
  - `ready` = 0.
  - Both counters = 0.
  - State = PLL_RST, internal timer = 0, synchronizer flops = 0.
  - Asserting `rst` mid-sequence aborts at once, with no partial release.
- Synchronizer: 2-flop synchronizer on `pll_locked`. `lk` denotes the synchronized value (2-cycle latency). All decisions use `lk` only.
- State machine, one timer reused across states and cleared on every state change:
  - PLL_RST:
    - `pll_rst` = 1, `dom_rst` = all ones.
    - After PLL_RST_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK:
    - `pll_rst` = 0.
    - If `lk` = 1 → STABLE.
    - Else if the timer reaches LOCK_TIMEOUT → PLL_RST, and `retry_count` increments.
  - STABLE:
    - If `lk` = 0 → WAIT_LOCK, with the timer restarted. No counter increments, because lock was never qualified.
    - If `lk` stays 1 for STABLE_CYCLES consecutive cycles → RELEASE.
  - RELEASE:
    - On entry, `dom_rst[0]` clears.
    - Every RELEASE_GAP cycles the next bit clears.
    - When bit NUM_DOMAINS-1 clears → RUN.
  - RUN:
    - `ready` = 1 from the cycle after the last bit clears, and stays 1 while `lk` = 1.
- Lock loss:
  - In RELEASE or RUN, `lk` = 0 causes, on the next edge:
    - `dom_rst` = all ones, `ready` = 0.
    - `lost_count` increments.
    - State → PLL_RST.
  - Lock loss takes priority over a release step scheduled for the same cycle.
- Released reset bits only ever go 1→0 in ascending index order. Once a bit is cleared it stays cleared until the sequence restarts.
- Counters saturate at 2^CNT_W − 1 with no wrap, and clear only on `rst`.
- End-to-end latency from `pll_locked` rising (held steady) to `ready`:
  - 2 cycles (synchronizer), plus
  - STABLE_CYCLES, plus
  - (NUM_DOMAINS−1)·RELEASE_GAP, plus
  - 1 cycle, give or take one cycle for the state-entry edge.
  - The implementation must document the exact figure, and the bench checks that exact value.
- Glitch rule: a `pll_locked` pulse shorter than 1 cycle may or may not be seen. Once `lk` is sampled, it is acted on deterministically.

Test Plan:
- Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=10, RELEASE_GAP=3, NUM_DOMAINS=6.
- Nominal bring-up: release `rst`; raise `pll_locked` at cycle 10 →
  - `pll_rst` high for exactly 4 cycles;
  - `dom_rst` clears bit-by-bit, 3 cycles apart: 6'b111110, 111100, …, 000000;
  - `ready` = 1 at the documented cycle;
  - both counters = 0.
- Timeout retry: hold `pll_locked` = 0 →
  - `pll_rst` re-pulses every 4+20 cycles;
  - `retry_count` reaches 3 after 3 timeouts;
  - `dom_rst` stays 6'b111111.
- Unstable lock: `pll_locked` high for 5 cycles, low for 2, then high →
  - no domain release until 10 consecutive `lk` cycles;
  - `lost_count` = 0.
- Loss in RUN: after `ready` = 1, drop `pll_locked` for 1 cycle →
  - `dom_rst` = 6'b111111 and `ready` = 0 within 3 cycles;
  - `lost_count` = 1;
  - `pll_rst` pulses, then full re-sequence.
- Loss mid-RELEASE: drop lock after 2 bits are released →
  - all bits re-asserted together;
  - `lost_count` increments;
  - no further single-bit release occurs.
- Saturation and reset: with CNT_W=2, force 5 timeouts → `retry_count` = 3. Assert `rst` mid-RELEASE → all outputs return to their reset values on the next edge.
